// File: rtl/layer_scheduler.sv
// rtl/layer_scheduler.sv - sequences NUM_LAYERS passes through one shared layer datapath
module layer_scheduler #(
  parameter int NUM_LAYERS     = 2,
  parameter int VLEN           = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int LIW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int VW  = 32 * VLEN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [VW-1:0]  in_vec,
  input  logic           dp_done,
  input  logic [VW-1:0]  dp_result,
  output logic [VW-1:0]  dp_in,
  output logic           dp_restart,
  output logic [LIW-1:0] layer_idx,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [VW-1:0]  result
);

  // RUN counter only has to reach TIMEOUT_CYCLES-1: the timeout fires in that cycle
  localparam int RCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    SETTLE,
    DONE
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [VW-1:0]  act;
  logic [RCW-1:0] run_cnt;
  logic [SCW-1:0] settle_cnt;

  logic run_accept;
  logic run_timeout;
  logic settle_last;
  logic last_layer;

  // The activation register feeds the datapath directly; no arithmetic here
  assign dp_in = act;

  // A done seen in the very first RUN cycle may be left over from the previous
  // pass, so only later RUN cycles may accept it. Acceptance wins over timeout.
  assign run_accept  = (state == RUN) && dp_done && (run_cnt != '0);
  assign run_timeout = (state == RUN) && !run_accept &&
                       (run_cnt == RCW'(TIMEOUT_CYCLES - 1));
  assign settle_last = (state == SETTLE) && (settle_cnt == SCW'(1));
  assign last_layer  = (layer_idx == LIW'(NUM_LAYERS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and per-state strobes
  always_comb begin
    next_state = state;
    dp_restart = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        dp_restart = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        if (run_accept) begin
          next_state = SETTLE;
        end else if (run_timeout) begin
          next_state = DONE;
        end
      end
      SETTLE: begin
        if (settle_last) begin
          next_state = last_layer ? DONE : LOAD;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Activation, layer index, counters, error flag and final result
  always_ff @(posedge clk) begin
    if (rst) begin
      act        <= '0;
      result     <= '0;
      layer_idx  <= '0;
      error      <= 1'b0;
      run_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            act       <= in_vec;
            layer_idx <= '0;
            error     <= 1'b0;
          end
        end
        LOAD: begin
          run_cnt <= '0;
        end
        RUN: begin
          if (run_accept) begin
            settle_cnt <= SCW'(SETTLE_CYCLES);
          end else if (run_timeout) begin
            // Abort without capturing: act and result keep their old values
            error <= 1'b1;
          end else begin
            run_cnt <= run_cnt + RCW'(1);
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - SCW'(1);
          if (settle_last) begin
            act <= dp_result;
            if (last_layer) begin
              // result mirrors the act value being captured on this same edge
              result <= dp_result;
            end else begin
              layer_idx <= layer_idx + LIW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// tb/tb_layer_scheduler.sv - scoreboard bench for layer_scheduler with a datapath stub
module tb_layer_scheduler;

  localparam int NL = 2;
  localparam int VL = 4;
  localparam int SC = 2;
  localparam int TO = 8;
  localparam int W  = 32 * VL;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] in_vec;
  logic         dp_done;
  logic [W-1:0] dp_result;
  logic [W-1:0] dp_in;
  logic         dp_restart;
  logic [0:0]   layer_idx;
  logic         busy;
  logic         done;
  logic         error;
  logic [W-1:0] result;

  layer_scheduler #(
    .NUM_LAYERS(NL),
    .VLEN(VL),
    .SETTLE_CYCLES(SC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_vec(in_vec),
    .dp_done(dp_done),
    .dp_result(dp_result),
    .dp_in(dp_in),
    .dp_restart(dp_restart),
    .layer_idx(layer_idx),
    .busy(busy),
    .done(done),
    .error(error),
    .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int done_count = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           dcyc;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] exp_prev = '0;

  int delays[NL];
  bit stale = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [W-1:0] add_k(input logic [W-1:0] v, input real k);
    logic [W-1:0] o;
    for (int i = 0; i < VL; i++) o[32*i +: 32] = r2f(f2r(v[32*i +: 32]) + k);
    return o;
  endfunction

  function automatic logic [W-1:0] gen_vec();
    logic [W-1:0] v;
    for (int i = 0; i < VL; i++) v[32*i +: 32] = r2f(real'($urandom_range(0, 1000)));
    return v;
  endfunction

  // Network-level model: every layer adds 1.0, each layer costs LOAD + R + settle,
  // a layer whose done never comes within TO RUN cycles ends the run with error.
  function automatic exp_t model(input logic [W-1:0] v, input int d0, input int d1,
                                 input bit st, input int s);
    exp_t e;
    int   d[NL];
    int   t;
    d     = '{d0, d1};
    t     = s + 1;
    e.err = 1'b0;
    e.res = add_k(v, real'(NL));
    for (int i = 0; i < NL; i++) begin
      int r;
      r = st ? 2 : d[i];
      if (r > TO) begin
        e.err = 1'b1;
        e.res = exp_prev;
        t     = t + 1 + TO;
        break;
      end
      t = t + 1 + r + SC;
    end
    e.dcyc = t;
    return e;
  endfunction

  // Datapath stub: result = input + 1.0, done raised a programmed delay after restart
  initial begin
    int rcyc;
    int rdelay;
    rcyc      = -1;
    rdelay    = 0;
    dp_done   = 1'b0;
    dp_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (dp_restart) begin
        rcyc      = cyc;
        rdelay    = delays[int'(layer_idx)];
        dp_result = add_k(dp_in, 1.0);
      end
      dp_done = stale || (rcyc >= 0 && cyc >= rcyc + rdelay);
    end
  end

  // Monitor: every done pulse pops one expectation
  initial begin
    bit busy_next;
    busy_next = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_next) begin
        chk("busy_after_done", W'(busy), W'(1'b0));
        busy_next = 1'b0;
      end
      if (done === 1'b1) begin
        exp_t e;
        done_count++;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("result", result, e.res);
          chk("error", W'(error), W'(e.err));
          chk_int("done_cycle", cyc, e.dcyc);
          busy_next = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [W-1:0] v, input int d0, input int d1,
                           input bit st, output int s);
    exp_t e;
    delays[0] = d0;
    delays[1] = d1;
    stale     = st;
    s         = cyc;
    e         = model(v, d0, d1, st, s);
    if (!e.err) exp_prev = e.res;
    sb_q.push_back(e);
    in_vec = v;
    start  = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wait_done: got no done within 100 cycles expected done");
    end
    tick();
  endtask

  task automatic do_run(input logic [W-1:0] v, input int d0, input int d1, input bit st);
    int s;
    start_run(v, d0, d1, st, s);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int rq[$];
    int dc0;
    rst    = 1'b1;
    start  = 1'b0;
    in_vec = '0;
    delays = '{3, 3};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_busy", W'(busy), W'(1'b0));
    chk("rst_done", W'(done), W'(1'b0));
    chk("rst_error", W'(error), W'(1'b0));
    chk("rst_layer_idx", W'(layer_idx), W'(1'b0));
    chk("rst_result", result, '0);
    chk("rst_dp_in", dp_in, '0);
    chk("rst_dp_restart", W'(dp_restart), W'(1'b0));

    // Nominal two-layer run with restart/layer timing
    start_run(gen_vec(), 3, 3, 1'b0, s);
    for (int rel = 1; rel <= 13; rel++) begin
      if (dp_restart) rq.push_back(cyc - s);
      if (rel == 6) chk("layer_idx_rel6", W'(layer_idx), W'(1'b0));
      if (rel == 7) chk("layer_idx_rel7", W'(layer_idx), W'(1'b1));
      tick();
    end
    chk_int("restart_count", rq.size(), 2);
    if (rq.size() == 2) begin
      chk_int("restart0_rel", rq[0], 1);
      chk_int("restart1_rel", rq[1], 7);
    end

    // Stale done held high
    do_run(gen_vec(), 3, 3, 1'b1);
    stale = 1'b0;

    // Timeout in layer 0, then back-to-back start clears error
    do_run(gen_vec(), 20, 3, 1'b0);
    start_run(gen_vec(), 3, 3, 1'b0, s);
    chk("b2b_error_cleared", W'(error), W'(1'b0));
    chk("b2b_layer_idx", W'(layer_idx), W'(1'b0));
    wait_done();

    // Timeout boundary: layer 0 done at the last allowed cycle, layer 1 one past it
    do_run(gen_vec(), 8, 9, 1'b0);
    do_run(gen_vec(), 3, 3, 1'b0);

    // Start while busy is ignored
    dc0 = done_count;
    start_run(gen_vec(), 3, 3, 1'b0, s);
    tick();
    tick();
    tick();
    in_vec = gen_vec();
    start  = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    repeat (20) tick();
    chk_int("busy_start_done_count", done_count - dc0, 1);

    // Reset during SETTLE aborts silently
    start_run(gen_vec(), 3, 3, 1'b0, s);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb_q.pop_back());
    exp_prev = '0;
    chk("mid_rst_busy", W'(busy), W'(1'b0));
    chk("mid_rst_layer_idx", W'(layer_idx), W'(1'b0));
    chk("mid_rst_result", result, '0);
    repeat (15) tick();
    do_run(gen_vec(), 3, 3, 1'b0);

    // Randomized back-to-back runs
    for (int i = 0; i < 25; i++) begin
      do_run(gen_vec(), int'($urandom_range(2, 10)), int'($urandom_range(2, 10)),
             ($urandom_range(0, 4) == 0));
    end

    repeat (5) tick();
    chk_int("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
